pipeline_hazard_unit: RTL
=========================

# pipeline_hazard_unit

Hazard controller for the five-stage pipeline. It keeps a shadow scoreboard of destination and control fields for the EX, MEM and WB stages, advancing in lock-step with the stage registers. From that scoreboard and the decode-stage operands it drives stall and flush back into the fetch and stage registers, and drives forwarding selects into the execute stage. It sits beside the datapath as the consumer of the decode/execute control bundle.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 32: width of the performance counters (used only when the configuration macro is defined).

Ports:
- `clk` input 1: the single clock. All state updates on the negedge, matching the stage registers.
- `rst_n` input 1: reset, synchronous and active-low.
- `rs1_d`, `rs2_d` input REG_ADDR_W: source registers of the instruction in decode.
- `rd_d` input REG_ADDR_W: destination of the decode instruction.
- `register_write_d` input 1: decode instruction writes the register file.
- `result_src_d` input 2: result source. 2'b01 means load.
- `mem_write_enable_d` input 1: decode instruction is a store.
- `pc_src_ex` input 1: branch or jump taken, resolved in EX.
- `mem_ready` input 1: data memory has completed the MEM-stage access.
- `stall_f`, `stall_d` output 1: hold the PC and the fetch/decode register.
- `stall_ex`, `stall_m` output 1: hold the decode/execute and execute/memory registers.
- `flush_d`, `flush_ex` output 1: load a bubble into fetch/decode and decode/execute.
- `forward_a_ex`, `forward_b_ex` output 2: ALU operand select. 2'b00 selects the register file, 2'b10 the MEM ALU result, 2'b01 the WB result.

## Operation
- Shadow slots EX, MEM and WB each hold: rs1, rs2, rd, register_write, result_src, mem_access.
- A bubble is all fields zero.
- Each negedge, when not frozen:
  - EX takes the D fields, or a bubble if `flush_ex` is asserted.
  - MEM takes EX.
  - WB takes MEM.
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
  - RUN to MEM_WAIT when MEM.mem_access=1 and `mem_ready`=0.
  - RUN to LOAD_STALL when EX.result_src=01, EX.rd≠0, and EX.rd matches rs1_d or rs2_d, and `pc_src_ex`=0.
  - LOAD_STALL returns to RUN after exactly one cycle.
  - MEM_WAIT returns to RUN on the edge where `mem_ready`=1.
- Outputs:
  - MEM_WAIT, or RUN with a pending memory miss: all four stalls=1, flushes=0. The scoreboard is frozen.
  - Branch taken (`pc_src_ex`=1): `flush_d`=1 and `flush_ex`=1. A load-use hazard detected in the same cycle is suppressed.
  - Load-use: `stall_f`=1, `stall_d`=1, `flush_ex`=1.
  - Priority: memory wait, then branch, then load-use.
- Forwarding, for operand A; operand B is identical using rs2:
  - 2'b10 if MEM.register_write, MEM.rd≠0 and MEM.rd==EX.rs1.
  - Otherwise 2'b01 if WB.register_write, WB.rd≠0 and WB.rd==EX.rs1.
  - Otherwise 2'b00.
  - MEM takes precedence over WB.
- Register x0 never causes a hazard or a forward.

## Timing
- Outputs are combinational from the registered scoreboard, the FSM state and the decode inputs. They are valid before the next negedge.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- Reset (`rst_n`=0 sampled at a negedge):
  - All slots become bubbles, FSM goes to RUN, counters clear.
  - While `rst_n`=0, outputs are forced: `flush_d`=1, `flush_ex`=1, all stalls 0, forwards 00.
- Reset during MEM_WAIT abandons the wait. No stall is held after reset.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds outputs `stall_cycles` and `flush_events`, each CNT_W wide.
  - `stall_cycles` increments once per cycle in which any stall is asserted.
  - `flush_events` increments once per taken branch.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Package `hazard_pkg` holds:
  - the state enum (RUN, LOAD_STALL, MEM_WAIT);
  - the forward-select localparams FWD_RF, FWD_WB, FWD_MEM;
  - RESULT_SRC_LOAD = 2'b01;
  - the `stage_info_t` struct for the slot fields.
- One sub-module, `forward_select`: combinational compare of one source register against the MEM and WB slots. It is instanced twice, for A and B.

## Test plan
- `lw x5`, then `add x6,x5,x1` in decode → one cycle with `stall_f`=`stall_d`=`flush_ex`=1, then `forward_a_ex`=01.
- `add x3,...`, then `sub x4,x3,x3` → `forward_a_ex`=`forward_b_ex`=10. With one unrelated instruction between them → 01.
- `pc_src_ex`=1 while a load-use hazard is also present → `flush_d`=`flush_ex`=1, `stall_f`=0, FSM stays in RUN.
- Load in MEM with `mem_ready`=0 for 3 cycles → all stalls=1 for those 3 cycles and the scoreboard is unchanged. Release on the 4th.
- `rst_n`=0 during MEM_WAIT → next cycle FSM is RUN, stalls 0, forwards 00.
- A write to x0 followed by a read of x0 → forwards 00, no stall.
- With the macro defined, drive 2^CNT_W+1 stall cycles (small CNT_W) → `stall_cycles` saturates at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard unit.
// Holds the FSM state enum, forwarding select codes, the load result-source
// code and the per-stage shadow scoreboard record.
package hazard_pkg;

    // Scoreboard register fields are stored at this fixed width so the record
    // can live in the package; narrower register indices are zero-extended.
    localparam int SB_ADDR_W = 8;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] rs1;
        logic [SB_ADDR_W-1:0] rs2;
        logic [SB_ADDR_W-1:0] rd;
        logic                 register_write;
        logic [1:0]           result_src;
        logic                 mem_access;
    } stage_info_t;

    localparam stage_info_t BUBBLE = '0;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [SB_ADDR_W-1:0] rd,
                                       input logic [SB_ADDR_W-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_select.sv
// forward_select: picks the ALU operand source for one EX source register by
// comparing it against the destinations held in the MEM and WB slots.
module forward_select
    import hazard_pkg::*;
(
    input  logic [SB_ADDR_W-1:0] i_rs,
    input  logic [SB_ADDR_W-1:0] i_mem_rd,
    input  logic                 i_mem_wr,
    input  logic [SB_ADDR_W-1:0] i_wb_rd,
    input  logic                 i_wb_wr,
    output logic [1:0]           o_fwd
);

    // MEM holds the younger producer, so it wins over WB
    always_comb begin
        o_fwd = FWD_RF;
        if (i_mem_wr && reg_match(i_mem_rd, i_rs)) begin
            o_fwd = FWD_MEM;
        end else if (i_wb_wr && reg_match(i_wb_rd, i_rs)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall/flush/forward control for the five-stage pipe.
// Keeps a shadow scoreboard (EX/MEM/WB) that advances on the negedge with the
// stage registers. Optional performance counters are enabled by defining
// HAZARD_PERF_CNT_EN. REG_ADDR_W must not exceed hazard_pkg::SB_ADDR_W.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  register_write_d,
    input  logic [1:0]            result_src_d,
    input  logic                  mem_write_enable_d,
    input  logic                  pc_src_ex,
    input  logic                  mem_ready,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_ex,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_ex,
    output logic [1:0]            forward_a_ex,
    output logic [1:0]            forward_b_ex
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
`endif
);

    stage_info_t r_ex, r_mem, r_wb;
    stage_info_t w_d_info;
    hz_state_e   r_state, w_state_nxt;
    logic        w_mem_stall;
    logic        w_load_use;
    logic [1:0]  w_fwd_a, w_fwd_b;

    // Decode-stage bundle widened into a scoreboard record
    always_comb begin
        w_d_info                = BUBBLE;
        w_d_info.rs1            = SB_ADDR_W'(rs1_d);
        w_d_info.rs2            = SB_ADDR_W'(rs2_d);
        w_d_info.rd             = SB_ADDR_W'(rd_d);
        w_d_info.register_write = register_write_d;
        w_d_info.result_src     = result_src_d;
        w_d_info.mem_access     = mem_write_enable_d || (result_src_d == RESULT_SRC_LOAD);
    end

    // Hazard detection. The memory stall drops in the same cycle mem_ready
    // rises so the completing access is captured on that edge.
    always_comb begin
        w_mem_stall = ((r_state == MEM_WAIT) || r_mem.mem_access) && !mem_ready;
        w_load_use  = (r_ex.result_src == RESULT_SRC_LOAD) &&
                      (reg_match(r_ex.rd, w_d_info.rs1) || reg_match(r_ex.rd, w_d_info.rs2));
    end

    // Shadow scoreboard, frozen while memory is outstanding
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_ex  <= BUBBLE;
            r_mem <= BUBBLE;
            r_wb  <= BUBBLE;
        end else if (!w_mem_stall) begin
            r_ex  <= flush_ex ? BUBBLE : w_d_info;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // FSM state register
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; a taken branch squashes a coincident load-use
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                end else if (w_load_use && !pc_src_ex) begin
                    w_state_nxt = LOAD_STALL;
                end
            end
            LOAD_STALL: w_state_nxt = RUN;
            MEM_WAIT:   if (mem_ready) w_state_nxt = RUN;
            default:    w_state_nxt = RUN;
        endcase
    end

    // Outputs: reset override, then memory wait > branch > load-use
    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_ex     = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_ex     = 1'b0;
        forward_a_ex = w_fwd_a;
        forward_b_ex = w_fwd_b;
        if (!rst_n) begin
            flush_d      = 1'b1;
            flush_ex     = 1'b1;
            forward_a_ex = FWD_RF;
            forward_b_ex = FWD_RF;
        end else if (w_mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_ex = 1'b1;
            stall_m  = 1'b1;
        end else if (pc_src_ex) begin
            flush_d  = 1'b1;
            flush_ex = 1'b1;
        end else if (w_load_use) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            flush_ex = 1'b1;
        end
    end

    forward_select u_fwd_a (
        .i_rs     (r_ex.rs1),
        .i_mem_rd (r_mem.rd),
        .i_mem_wr (r_mem.register_write),
        .i_wb_rd  (r_wb.rd),
        .i_wb_wr  (r_wb.register_write),
        .o_fwd    (w_fwd_a)
    );

    forward_select u_fwd_b (
        .i_rs     (r_ex.rs2),
        .i_mem_rd (r_mem.rd),
        .i_mem_wr (r_mem.register_write),
        .i_wb_rd  (r_wb.rd),
        .i_wb_wr  (r_wb.register_write),
        .o_fwd    (w_fwd_b)
    );

    // WB only needs rd/register_write; the rest rides along for debug visibility
    logic w_unused_wb;
    assign w_unused_wb = ^{r_wb.rs1, r_wb.rs2, r_wb.result_src, r_wb.mem_access};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles, r_flush_events;

    // Saturating event counters
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if ((stall_f || stall_d || stall_ex || stall_m) && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (pc_src_ex && !w_mem_stall && !(&r_flush_events)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
